// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } i2c_tgt_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser and edge detector for one I2C line (SCL or SDA).
// Optional macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the 2-flop synchroniser (rejects 1-clk pulses, +2 clk latency).
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic lvl_d;
  logic lvl_prev;

  // Two-flop synchroniser; resets to the idle-high bus level so no false edges appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= line_in;
      sync_2 <= sync_1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Majority of the current and two previous synced samples, registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync_2};
      filt <= (sync_2 & hist[0]) | (sync_2 & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign lvl_d = filt;
`else
  assign lvl_d = sync_2;
`endif

  // One-clock delayed copy of the cleaned level, used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_prev <= 1'b1;
    end else begin
      lvl_prev <= lvl_d;
    end
  end

  assign lvl  = lvl_d;
  assign rise = lvl_d & ~lvl_prev;
  assign fall = ~lvl_d & lvl_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank, oversampling SCL/SDA on clk.
// SDA is driven open-drain through sda_oen_n; SCL is never driven.
// Optional macro I2C_TGT_GLITCH_FILTER_EN enables input glitch filtering
// inside i2c_line_sync.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR  = 7'h68,
  parameter int         NREGS = 8,
  localparam int        AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oen_n,
  input  logic              hw_we,
  input  logic [AW-1:0]     hw_addr,
  input  logic [7:0]        hw_data,
  output logic [8*NREGS-1:0] reg_q,
  output logic              wr_strobe,
  output logic [AW-1:0]     wr_addr,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_tgt_state_e state;
  logic [2:0]     bit_cnt;
  logic           bit_full;
  logic [7:0]     shift;
  logic [7:0]     tx_byte;
  logic           rw;
  logic           first_byte;
  logic [AW-1:0]  ptr;
  logic [7:0]     bank [NREGS];

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (scl_in),
    .lvl     (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (sda_in),
    .lvl     (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  // Protocol FSM plus register bank; I2C writes are placed after host writes so they win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      bit_full   <= 1'b0;
      shift      <= 8'h00;
      tx_byte    <= 8'h00;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= '0;
      sda_oen_n  <= 1'b1;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      for (int k = 0; k < NREGS; k++) bank[k] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (hw_we) bank[hw_addr] <= hw_data;

      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        bit_full  <= 1'b0;
        sda_oen_n <= 1'b1;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        sda_oen_n <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_ADDR: begin
            if (scl_rise) begin
              shift    <= {shift[6:0], sda_lvl};
              bit_cnt  <= bit_cnt + 3'd1;
              bit_full <= (bit_cnt == 3'd7);
            end else if (scl_fall && bit_full) begin
              bit_full <= 1'b0;
              if (shift[7:1] == ADDR) begin
                state     <= ST_ADDR_ACK;
                sda_oen_n <= I2C_ACK;
                busy      <= 1'b1;
                rw        <= shift[0];
              end else begin
                state     <= ST_IDLE;
                sda_oen_n <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt  <= 3'd0;
              bit_full <= 1'b0;
              if (!rw) begin
                state      <= ST_WR_BYTE;
                first_byte <= 1'b1;
                sda_oen_n  <= 1'b1;
              end else begin
                state     <= ST_RD_BYTE;
                tx_byte   <= bank[ptr];
                sda_oen_n <= bank[ptr][7];
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              shift    <= {shift[6:0], sda_lvl};
              bit_cnt  <= bit_cnt + 3'd1;
              bit_full <= (bit_cnt == 3'd7);
            end else if (scl_fall && bit_full) begin
              bit_full  <= 1'b0;
              sda_oen_n <= I2C_ACK;
              state     <= ST_WR_ACK;
              if (first_byte) begin
                ptr        <= shift[AW-1:0];
                first_byte <= 1'b0;
              end else begin
                bank[ptr] <= shift;
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                ptr       <= ptr + AW'(1);
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oen_n <= 1'b1;
              state     <= ST_WR_BYTE;
              bit_cnt   <= 3'd0;
            end
          end
          ST_RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt  <= bit_cnt + 3'd1;
              bit_full <= (bit_cnt == 3'd7);
            end else if (scl_fall) begin
              if (bit_full) begin
                bit_full  <= 1'b0;
                sda_oen_n <= 1'b1;
                state     <= ST_RD_ACK;
                ptr       <= ptr + AW'(1);
              end else begin
                sda_oen_n <= tx_byte[3'd7 - bit_cnt];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                state   <= ST_RD_BYTE;
                tx_byte <= bank[ptr];
                bit_cnt <= 3'd0;
              end else begin
                state     <= ST_IDLE;
                sda_oen_n <= 1'b1;
                busy      <= 1'b0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Flatten the bank onto the reg_q bus, register k at bits [8k+7:8k].
  always_comb begin
    reg_q = '0;
    for (int k = 0; k < NREGS; k++) reg_q[8*k +: 8] = bank[k];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bit-banged I2C master, transaction-level
// register model, and a per-cycle compare process.
module tb_i2c_target_regs;

  localparam int NREGS = 8;
  localparam int H     = 12;
  localparam logic [6:0] TGT = 7'h68;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m, sda_m;
  logic        sda_line;
  logic        sda_oen_n;
  logic        hw_we;
  logic [2:0]  hw_addr;
  logic [7:0]  hw_data;
  logic [63:0] reg_q;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        busy;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_exp_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mdl [NREGS];
  int         mptr;
  logic       cmp_en;
  wr_exp_t    exp_q[$];
  int         strobe_log[$];
  logic [7:0] wr_data [4];
  logic [7:0] rd_vals [4];

  always #5 clk = ~clk;

  assign sda_line = sda_m & sda_oen_n;

  i2c_target_regs #(.ADDR(TGT), .NREGS(NREGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oen_n (sda_oen_n),
    .hw_we     (hw_we),
    .hw_addr   (hw_addr),
    .hw_data   (hw_data),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int k = 0; k < NREGS; k++) f[8*k +: 8] = mdl[k];
    return f;
  endfunction

  // Compare process: every write strobe against the expected-write queue, and the whole
  // bank plus idle outputs against the model whenever the bus is quiet.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_strobe === 1'b1) begin
        strobe_log.push_back(int'(wr_addr));
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          wr_exp_t e;
          e = exp_q.pop_front();
          check_output("strobe_addr", 64'(wr_addr), 64'(e.addr));
          check_output("strobe_data", 64'(reg_q[8*e.addr +: 8]), 64'(e.data));
        end
      end
      if (cmp_en) begin
        check_output("bank", reg_q, model_flat());
        check_output("idle_busy", 64'(busy), 64'd0);
        check_output("idle_sda", 64'(sda_oen_n), 64'd1);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    wait_clk(H/2);
    sda_m = b;
    wait_clk(H/2);
    scl_m = 1'b1;
    wait_clk(H);
    s = sda_line;
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(H/2);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(H/2);
    sda_m = 1'b0;
    wait_clk(H/2);
    scl_m = 1'b1;
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      v[i] = s;
    end
    send_bit(mack, s);
  endtask

  task automatic hw_write(input logic [2:0] a, input logic [7:0] d);
    hw_addr = a;
    hw_data = d;
    hw_we   = 1'b1;
    wait_clk(1);
    hw_we   = 1'b0;
    mdl[a]  = d;
  endtask

  // Write transaction: address, pointer byte, then n data bytes from wr_data.
  task automatic apply_stimulus(input logic [6:0] a, input logic [7:0] p, input int n);
    logic ack;
    bit   match;
    match  = (a == TGT);
    cmp_en = 1'b0;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check_output("addr_ack", 64'(ack), match ? 64'd0 : 64'd1);
    if (match) begin
      check_output("busy_after_addr", 64'(busy), 64'd1);
      write_byte(p, ack);
      check_output("ptr_ack", 64'(ack), 64'd0);
      mptr = p % NREGS;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back('{mptr, wr_data[j]});
        mdl[mptr] = wr_data[j];
        write_byte(wr_data[j], ack);
        check_output("data_ack", 64'(ack), 64'd0);
        mptr = (mptr + 1) % NREGS;
      end
    end else begin
      check_output("busy_unaddressed", 64'(busy), 64'd0);
    end
    i2c_stop();
    wait_clk(8);
    cmp_en = 1'b1;
  endtask

  // Read transaction: set pointer, repeated START, read n bytes, NACK the last.
  task automatic read_txn(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] v;
    cmp_en = 1'b0;
    i2c_start();
    write_byte({TGT, 1'b0}, ack);
    check_output("rd_addr_w_ack", 64'(ack), 64'd0);
    write_byte(p, ack);
    check_output("rd_ptr_ack", 64'(ack), 64'd0);
    mptr = p % NREGS;
    i2c_start();
    write_byte({TGT, 1'b1}, ack);
    check_output("rd_addr_r_ack", 64'(ack), 64'd0);
    check_output("rd_busy", 64'(busy), 64'd1);
    for (int j = 0; j < n; j++) begin
      read_byte((j == n - 1) ? 1'b1 : 1'b0, v);
      rd_vals[j] = v;
      check_output("read_data", 64'(v), 64'(mdl[mptr]));
      mptr = (mptr + 1) % NREGS;
    end
    check_output("sda_after_nack", 64'(sda_oen_n), 64'd1);
    check_output("busy_after_nack", 64'(busy), 64'd0);
    i2c_stop();
    wait_clk(8);
    cmp_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete, actual=timeout required=finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n0;
    logic       s;
    logic       found;
    logic [6:0] ra;

    rst_n   = 1'b0;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    hw_we   = 1'b0;
    hw_addr = 3'd0;
    hw_data = 8'h00;
    cmp_en  = 1'b0;
    for (int k = 0; k < NREGS; k++) mdl[k] = 8'h00;

    wait_clk(4);
    check_output("rst_sda_oen_n", 64'(sda_oen_n), 64'd1);
    check_output("rst_reg_q", reg_q, 64'd0);
    check_output("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    check_output("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    wait_clk(4);
    cmp_en = 1'b1;

    // Basic write of two bytes from pointer 2
    wr_data[0] = 8'hA5;
    wr_data[1] = 8'h3C;
    n0 = strobe_log.size();
    apply_stimulus(TGT, 8'h02, 2);
    check_output("t1_reg2", 64'(reg_q[23:16]), 64'hA5);
    check_output("t1_reg3", 64'(reg_q[31:24]), 64'h3C);
    check_output("t1_strobes", 64'(strobe_log.size() - n0), 64'd2);
    if (strobe_log.size() - n0 == 2) begin
      check_output("t1_strobe0", 64'(strobe_log[n0]), 64'd2);
      check_output("t1_strobe1", 64'(strobe_log[n0 + 1]), 64'd3);
    end

    // Pointer wrap from the last register to register 0
    wr_data[0] = 8'h11;
    wr_data[1] = 8'h22;
    apply_stimulus(TGT, 8'h07, 2);
    check_output("t2_reg7", 64'(reg_q[63:56]), 64'h11);
    check_output("t2_reg0", 64'(reg_q[7:0]), 64'h22);

    // Read back with repeated START
    read_txn(8'h02, 2);
    check_output("t3_rd0", 64'(rd_vals[0]), 64'hA5);
    check_output("t3_rd1", 64'(rd_vals[1]), 64'h3C);

    // Foreign address is ignored
    wr_data[0] = 8'hFF;
    n0 = strobe_log.size();
    apply_stimulus(7'h50, 8'h00, 1);
    check_output("t4_no_strobe", 64'(strobe_log.size() - n0), 64'd0);

    // Host write and I2C write hitting register 3 on the same clock
    wr_data[0] = 8'h99;
    cmp_en = 1'b0;
    fork
      apply_stimulus(TGT, 8'h03, 1);
      begin
        hw_addr = 3'd3;
        hw_data = 8'h77;
        hw_we   = 1'b1;
        found   = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
          @(posedge clk);
          #1;
          if (wr_strobe) found = 1'b1;
        end
        hw_we = 1'b0;
        check_output("t5_strobe_seen", 64'(found), 64'd1);
      end
    join
    check_output("t5_reg3", 64'(reg_q[31:24]), 64'h99);

    // Asynchronous reset in the middle of a read byte
    hw_write(3'd5, 8'h12);
    cmp_en = 1'b0;
    i2c_start();
    write_byte({TGT, 1'b0}, s);
    write_byte(8'h05, s);
    i2c_start();
    write_byte({TGT, 1'b1}, s);
    send_bit(1'b1, s);
    check_output("t6_bit7", 64'(s), 64'd0);
    send_bit(1'b1, s);
    check_output("t6_bit6", 64'(s), 64'd0);
    wait_clk(H/2);
    check_output("t6_driving", 64'(sda_oen_n), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_sda", 64'(sda_oen_n), 64'd1);
    check_output("t6_rst_bank", reg_q, 64'd0);
    check_output("t6_rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < NREGS; k++) mdl[k] = 8'h00;
    exp_q.delete();
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    cmp_en = 1'b1;
    wr_data[0] = 8'h5A;
    apply_stimulus(TGT, 8'h01, 1);
    read_txn(8'h01, 1);
    check_output("t6_after_rst", 64'(rd_vals[0]), 64'h5A);

    // Randomized mix of writes, reads and host writes against the model
    for (int it = 0; it < 14; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        ra = TGT;
        if ($urandom_range(0, 4) == 0) begin
          ra = 7'($urandom_range(0, 126));
          if (ra >= TGT) ra = ra + 7'd1;
        end
        for (int j = 0; j < 4; j++) wr_data[j] = 8'($urandom);
        apply_stimulus(ra, 8'($urandom), $urandom_range(1, 4));
      end else if (r < 8) begin
        read_txn(8'($urandom), $urandom_range(1, 3));
      end else begin
        hw_write(3'($urandom), 8'($urandom));
        wait_clk(2);
      end
    end

    wait_clk(10);
    check_output("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
